pow8_arbiter: RTL and testbench

POW8_ARBITER -- requirements
Module: pow8_arbiter

---
 rtl/pow8_arbiter.sv | 145 ++++++++++++++
 tb/tb_pow8_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow8_arbiter.sv
// Round-robin front end that shares one in-order pow8 engine among NUM_REQ requesters.
// Requester tags are queued in issue order so each engine result goes back to the channel that sent the operand.
module pow8_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int RES_W     = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      eng_s_valid,
  input  logic                      eng_s_ready,
  output logic [DATA_W-1:0]         eng_s_data,
  input  logic                      eng_m_valid,
  output logic                      eng_m_ready,
  input  logic [RES_W-1:0]          eng_m_data,
  output logic                      busy,
  output logic                      err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TAG_W = $clog2(TAG_DEPTH);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rrPtr;
  logic [PTR_W-1:0]   r_tags [TAG_DEPTH];
  logic [TAG_W-1:0]   r_wrPtr;
  logic [TAG_W-1:0]   r_rdPtr;
  logic [TAG_W:0]     r_count;
  logic               r_holdValid;
  logic [DATA_W-1:0]  r_holdData;
  logic               r_err;

  logic               w_grantAny;
  logic [PTR_W-1:0]   w_grantIdx;
  logic [PTR_W-1:0]   w_nextPtr;
  logic [DATA_W-1:0]  w_selData;
  logic [PTR_W-1:0]   w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_canAccept;
  logic               w_push;
  logic               w_pop;
  logic [TAG_W:0]     w_countNext;

  // Walk offsets from the far end so the requester closest to r_rrPtr wins.
  always_comb begin : p_grant
    int idx;
    w_grantAny = 1'b0;
    w_grantIdx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        w_grantAny = 1'b1;
        w_grantIdx = idx[PTR_W-1:0];
      end
    end
  end

  assign w_nextPtr   = (w_grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
  assign w_selData   = req_data[w_grantIdx*DATA_W +: DATA_W];
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_head      = r_tags[r_rdPtr];
  // A full FIFO blocks acceptance even when a pop frees a slot this cycle.
  assign w_canAccept = en && (r_state == ST_RUN) && !w_full && (!r_holdValid || eng_s_ready);
  assign w_push      = w_canAccept && w_grantAny;
  assign eng_m_ready = rsp_ready[w_head] && !w_empty;
  assign w_pop       = eng_m_valid && eng_m_ready;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (w_push) req_ready[w_grantIdx] = 1'b1;
    rsp_valid[w_head] = eng_m_valid && !w_empty;
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
  end

  assign rsp_data    = eng_m_data;
  assign eng_s_valid = r_holdValid;
  assign eng_s_data  = r_holdData;
  assign busy        = (r_state != ST_IDLE);
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (en) r_state <= ST_RUN;
        ST_RUN:   if (!en) r_state <= (w_countNext == '0) ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: begin
          if (en) r_state <= ST_RUN;
          else if (w_countNext == '0) r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr     <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_holdValid <= 1'b0;
      r_holdData  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wrPtr] <= w_grantIdx;
        r_wrPtr         <= r_wrPtr + 1'b1;
        r_rrPtr         <= w_nextPtr;
        r_holdValid     <= 1'b1;
        r_holdData      <= w_selData;
      end else if (r_holdValid && eng_s_ready) begin
        r_holdValid <= 1'b0;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= w_countNext;
      // A result with no tag outstanding means the engine and arbiter disagree.
      if (eng_m_valid && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pow8_arbiter.sv
// Directed bench for pow8_arbiter with a behavioural in-order pow8 engine.
// Expected grants and results are hand-computed constants.
module tb_pow8_arbiter;

  logic         clk;
  logic         reset;
  logic         en;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [63:0]  rsp_data;
  logic         eng_s_valid;
  logic         eng_s_ready;
  logic [31:0]  eng_s_data;
  logic         eng_m_valid;
  logic         eng_m_ready;
  logic [63:0]  eng_m_data;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  pow8_arbiter #(.NUM_REQ(4), .DATA_W(32), .RES_W(64), .TAG_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .eng_s_valid(eng_s_valid), .eng_s_ready(eng_s_ready), .eng_s_data(eng_s_data),
    .eng_m_valid(eng_m_valid), .eng_m_ready(eng_m_ready), .eng_m_data(eng_m_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural engine: in-order queue, reset together with the arbiter.
  logic [63:0] engRes [16];
  logic [3:0]  engWp;
  logic [3:0]  engRp;
  logic [4:0]  engCnt;
  logic        engOn;
  logic        engForce;
  logic [63:0] engForceData;
  logic        engPush;
  logic        engPop;

  function automatic logic [63:0] pow8(input logic [31:0] x);
    logic [63:0] v;
    v = {32'b0, x};
    return v * v * v * v * v * v * v * v;
  endfunction

  assign eng_m_valid = engForce || (engOn && engCnt != 5'd0);
  assign eng_m_data  = engForce ? engForceData : engRes[engRp];
  assign engPush     = eng_s_valid && eng_s_ready;
  assign engPop      = eng_m_valid && eng_m_ready && !engForce;

  always @(posedge clk) begin
    if (reset) begin
      engWp  <= 4'd0;
      engRp  <= 4'd0;
      engCnt <= 5'd0;
    end else begin
      if (engPush) begin
        engRes[engWp] <= pow8(eng_s_data);
        engWp         <= engWp + 4'd1;
      end
      if (engPop) engRp <= engRp + 4'd1;
      engCnt <= engCnt + 5'(engPush) - 5'(engPop);
    end
  end

  // Transaction log of grants and responses.
  int          grantLog [64];
  int          rspCh [64];
  logic [63:0] rspDat [64];
  int          nGrant = 0;
  int          nRsp   = 0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i] && nGrant < 64) begin
          grantLog[nGrant] <= i;
          nGrant           <= nGrant + 1;
        end
        if (rsp_valid[i] && rsp_ready[i] && nRsp < 64) begin
          rspCh[nRsp]  <= i;
          rspDat[nRsp] <= rsp_data;
          nRsp         <= nRsp + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; optionally drops req_valid bits that were accepted.
  task automatic applyStimulus(input bit clearAcc);
    logic [3:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (clearAcc) req_valid = req_valid & ~acc;
  endtask

  task automatic doReset();
    reset     = 1'b1;
    en        = 1'b0;
    req_valid = 4'b0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    reset = 1'b0;
  endtask

  logic [63:0] expRes [4];
  int gb;
  int rb;

  initial begin
    reset        = 1'b1;
    en           = 1'b0;
    req_valid    = 4'b0;
    req_data     = '0;
    rsp_ready    = 4'hF;
    eng_s_ready  = 1'b1;
    engOn        = 1'b1;
    engForce     = 1'b0;
    engForceData = 64'd0;
    expRes[0] = 64'd1;
    expRes[1] = 64'd256;
    expRes[2] = 64'd6561;
    expRes[3] = 64'd65536;

    // Reset values
    doReset();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_eng_s_valid", 64'(eng_s_valid), 64'd0);
    checkOutput("rst_eng_m_ready", 64'(eng_m_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);

    // Single request from channel 1 with operand 2
    en = 1'b1;
    req_data[63:32] = 32'd2;
    req_valid = 4'b0010;
    #1;
    checkOutput("idle_no_ready", 64'(req_ready), 64'd0);
    applyStimulus(1'b1);
    checkOutput("run_ready1", 64'(req_ready), 64'b0010);
    checkOutput("run_busy", 64'(busy), 64'd1);
    applyStimulus(1'b1);
    checkOutput("s_valid_lat1", 64'(eng_s_valid), 64'd1);
    checkOutput("s_data_lat1", 64'(eng_s_data), 64'd2);
    applyStimulus(1'b1);
    checkOutput("s_valid_cleared", 64'(eng_s_valid), 64'd0);
    checkOutput("rsp_valid_ch1", 64'(rsp_valid), 64'b0010);
    checkOutput("rsp_data_256", rsp_data, 64'd256);
    applyStimulus(1'b1);
    checkOutput("rsp_valid_done", 64'(rsp_valid), 64'd0);

    // Four simultaneous requesters from rr_ptr=0
    doReset();
    en = 1'b1;
    req_data = {32'd4, 32'd3, 32'd2, 32'd1};
    req_valid = 4'hF;
    gb = nGrant;
    rb = nRsp;
    repeat (12) applyStimulus(1'b1);
    checkOutput("all4_grant_cnt", 64'(nGrant - gb), 64'd4);
    checkOutput("all4_rsp_cnt", 64'(nRsp - rb), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("all4_grant%0d", k), 64'(grantLog[gb + k]), 64'(k));
      checkOutput($sformatf("all4_rsp_ch%0d", k), 64'(rspCh[rb + k]), 64'(k));
      checkOutput($sformatf("all4_rsp_dat%0d", k), rspDat[rb + k], expRes[k]);
    end

    // Requesters 0 and 2 continuously valid
    doReset();
    en = 1'b1;
    req_valid = 4'b0101;
    gb = nGrant;
    applyStimulus(1'b0);
    repeat (6) applyStimulus(1'b0);
    req_valid = 4'b0;
    repeat (6) applyStimulus(1'b0);
    checkOutput("alt_grant_cnt", 64'(nGrant - gb), 64'd6);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("alt_grant%0d", k), 64'(grantLog[gb + k]), (k % 2 == 1) ? 64'd2 : 64'd0);

    // Tag FIFO full with the engine withholding results
    doReset();
    engOn = 1'b0;
    en = 1'b1;
    req_valid = 4'hF;
    gb = nGrant;
    rb = nRsp;
    repeat (13) applyStimulus(1'b0);
    checkOutput("full_accepts", 64'(nGrant - gb), 64'd8);
    checkOutput("full_no_ready", 64'(req_ready), 64'd0);
    engOn = 1'b1;
    #1;
    checkOutput("full_pop_same_cycle", 64'(req_ready), 64'd0);
    checkOutput("full_m_ready", 64'(eng_m_ready), 64'd1);
    applyStimulus(1'b0);
    checkOutput("after_pop_ready", 64'(req_ready), 64'b0001);
    req_valid = 4'b0;
    repeat (14) applyStimulus(1'b0);
    checkOutput("full_drained_rsp", 64'(nRsp - rb), 64'd8);
    checkOutput("full_drained_mv", 64'(eng_m_valid), 64'd0);

    // Stalled head requester blocks the one behind it
    doReset();
    engOn = 1'b0;
    en = 1'b1;
    rsp_ready = 4'b0010;
    req_data[31:0] = 32'd3;
    req_data[63:32] = 32'd2;
    req_valid = 4'b0011;
    repeat (4) applyStimulus(1'b1);
    engOn = 1'b1;
    #1;
    checkOutput("hol_m_ready", 64'(eng_m_ready), 64'd0);
    checkOutput("hol_rsp_valid", 64'(rsp_valid), 64'b0001);
    repeat (2) applyStimulus(1'b0);
    checkOutput("hol_m_ready_hold", 64'(eng_m_ready), 64'd0);
    checkOutput("hol_rsp_valid_hold", 64'(rsp_valid), 64'b0001);
    rsp_ready = 4'b0011;
    #1;
    checkOutput("hol_release", 64'(eng_m_ready), 64'd1);
    checkOutput("hol_data0", rsp_data, 64'd6561);
    applyStimulus(1'b0);
    checkOutput("hol_next_valid", 64'(rsp_valid), 64'b0010);
    checkOutput("hol_data1", rsp_data, 64'd256);
    applyStimulus(1'b0);
    rsp_ready = 4'hF;

    // Reset with three outstanding, then a spurious engine result
    doReset();
    engOn = 1'b0;
    en = 1'b1;
    req_valid = 4'b0111;
    repeat (5) applyStimulus(1'b1);
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    applyStimulus(1'b0);
    reset = 1'b0;
    en = 1'b0;
    req_valid = 4'b0;
    engOn = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_rst_s_valid", 64'(eng_s_valid), 64'd0);
    checkOutput("mid_rst_m_ready", 64'(eng_m_ready), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    engForce = 1'b1;
    engForceData = 64'h1234;
    #1;
    checkOutput("spur_m_ready", 64'(eng_m_ready), 64'd0);
    checkOutput("spur_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("spur_err_pre", 64'(err), 64'd0);
    applyStimulus(1'b0);
    checkOutput("spur_err_set", 64'(err), 64'd1);
    engForce = 1'b0;
    repeat (3) applyStimulus(1'b0);
    checkOutput("spur_err_sticky", 64'(err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
